// File: rtl/inert_integrator_p.sv
// inert_integrator_p
//   Gyro calibration and heading integration core. Averages 2^CAL_LOG2 yaw
//   rate samples to find the rate offset, then integrates offset-corrected,
//   deadbanded yaw rate into a wrapping signed heading. While a guardrail IR
//   detector is active, the heading is also nudged toward the nearest
//   quarter turn.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   strt_cal  pulse: start / restart calibration
//   vld       pulse: new yaw_rt sample
//   yaw_rt    signed raw yaw rate [RATE_W]
//   lftIR     left guardrail detector (enables fusion)
//   rghtIR    right guardrail detector (enables fusion)
//   moving    integration and fusion enabled while high
//   cal_done  one-cycle pulse when calibration completes
//   rdy       one-cycle pulse when heading has been updated (RUN only)
//   heading   signed heading [HEAD_W], full turn = 2^HEAD_W counts
//   LED       top 8 bits of heading
module inert_integrator_p #(
    parameter int FAST_SIM   = 1,
    parameter int CAL_LOG2   = FAST_SIM ? 8 : 11,
    parameter int RATE_W     = 16,
    parameter int HEAD_W     = 12,
    parameter int FRAC_W     = 11,
    parameter int DEADBAND   = 4,
    parameter int FUSE_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strt_cal,
    input  logic              vld,
    input  logic [RATE_W-1:0] yaw_rt,
    input  logic              lftIR,
    input  logic              rghtIR,
    input  logic              moving,
    output logic              cal_done,
    output logic              rdy,
    output logic [HEAD_W-1:0] heading,
    output logic [7:0]        LED
);

    localparam int ACC_W = HEAD_W + FRAC_W;
    localparam int SUM_W = RATE_W + CAL_LOG2;
    localparam int CNT_W = CAL_LOG2 + 1;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << CAL_LOG2) - 1);
    localparam logic signed [RATE_W-1:0] DB_POS   = RATE_W'(DEADBAND);
    localparam logic signed [RATE_W-1:0] DB_NEG   = -DB_POS;
    localparam logic [ACC_W-1:0]         HALF_Q   = ACC_W'(1) << (ACC_W - 3);
    localparam logic signed [ACC_W-1:0]  STEP_POS = ACC_W'(1) << FUSE_SHIFT;
    localparam logic signed [ACC_W-1:0]  STEP_NEG = -STEP_POS;

    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic signed [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]          cnt;
    logic signed [RATE_W-1:0]  offset;

    logic signed [SUM_W-1:0]   sum_nxt;
    logic signed [SUM_W-1:0]   avg;
    logic signed [RATE_W:0]    diff;
    logic signed [RATE_W-1:0]  corr;
    logic signed [RATE_W-1:0]  rate;
    logic [ACC_W-1:0]          rounded;
    logic [ACC_W-1:0]          target;
    logic signed [ACC_W-1:0]   err;
    logic signed [ACC_W-1:0]   fuse;
    logic signed [ACC_W-1:0]   acc_nxt;

    // Calibration running sum including the sample being accepted, so the
    // final average covers all 2^CAL_LOG2 samples in the same edge.
    always_comb begin
        sum_nxt = sum + {{CAL_LOG2{yaw_rt[RATE_W-1]}}, yaw_rt};
        avg     = sum_nxt >>> CAL_LOG2;
    end

    // Offset correction at RATE_W+1 bits, saturated back to RATE_W, then
    // deadband.
    always_comb begin
        diff = {yaw_rt[RATE_W-1], yaw_rt} - {offset[RATE_W-1], offset};
        if (diff[RATE_W] != diff[RATE_W-1])
            corr = diff[RATE_W] ? {1'b1, {(RATE_W-1){1'b0}}}
                                : {1'b0, {(RATE_W-1){1'b1}}};
        else
            corr = diff[RATE_W-1:0];
        rate = ((corr > DB_NEG) && (corr < DB_POS)) ? '0 : corr;
    end

    // Fusion: step toward the nearest quarter turn, clamped to 2^FUSE_SHIFT.
    // Rounding wraps modulo 2^ACC_W, so the top quarter rounds to 0.
    always_comb begin
        rounded = acc + HALF_Q;
        target  = {rounded[ACC_W-1:ACC_W-2], {(ACC_W-2){1'b0}}};
        err     = target - acc;
        if (!(lftIR || rghtIR))
            fuse = '0;
        else if (err > STEP_POS)
            fuse = STEP_POS;
        else if (err < STEP_NEG)
            fuse = STEP_NEG;
        else
            fuse = err;
        acc_nxt = acc + {{(ACC_W-RATE_W){rate[RATE_W-1]}}, rate} + fuse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            sum      <= '0;
            cnt      <= '0;
            offset   <= '0;
            cal_done <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            cal_done <= 1'b0;
            rdy      <= 1'b0;
            // strt_cal outranks a coincident vld, which is dropped.
            if (strt_cal) begin
                sum   <= '0;
                cnt   <= '0;
                acc   <= '0;
                state <= CAL;
            end else begin
                case (state)
                    IDLE: ;
                    CAL: begin
                        if (vld) begin
                            sum <= sum_nxt;
                            cnt <= cnt + CNT_W'(1);
                            if (cnt == CNT_LAST) begin
                                offset   <= avg[RATE_W-1:0];
                                cal_done <= 1'b1;
                                state    <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (vld) begin
                            rdy <= 1'b1;
                            if (moving)
                                acc <= acc_nxt;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign heading = acc[ACC_W-1 -: HEAD_W];
    assign LED     = heading[HEAD_W-1 -: 8];

endmodule

// File: doc/inert_integrator_p.md
# inert_integrator_p

Parametrised successor to `inert_intf`'s calibration and integration core. It averages `2^CAL_LOG2` gyro yaw-rate samples to find the rate offset, then integrates offset-corrected, deadbanded yaw rate into a wrapping signed heading. While a guardrail IR is active, it also pulls the heading toward the nearest quarter-turn. It sits between the SPI gyro reader, which supplies `vld`/`yaw_rt`, and the navigation/PID logic, which consumes `heading`/`rdy`.

## Interface
- `FAST_SIM`, 1: selects the default calibration length; `CAL_LOG2` = 8 when 1, 11 when 0.
- `CAL_LOG2`, `FAST_SIM ? 8 : 11`: log2 of the number of calibration samples.
- `RATE_W`, 16: width of `yaw_rt`.
- `HEAD_W`, 12: width of `heading`. A full turn is `2^HEAD_W` counts.
- `FRAC_W`, 11: fraction bits in the accumulator below the `heading` LSB.
- `DEADBAND`, 4: corrected rates with `|x| < DEADBAND` integrate as 0.
- `FUSE_SHIFT`, 4: fusion step is `2^FUSE_SHIFT` accumulator LSBs per `vld`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `strt_cal` in 1: single-cycle pulse that starts or restarts calibration.
- `vld` in 1: single-cycle pulse marking a new `yaw_rt` sample.
- `yaw_rt` in `RATE_W`: signed raw yaw rate.
- `lftIR`, `rghtIR` in 1: guardrail detectors; either one enables fusion.
- `moving` in 1: integration and fusion are enabled only while high.
- `cal_done` out 1: one-cycle pulse when calibration completes.
- `rdy` out 1: one-cycle pulse when `heading` has been updated.
- `heading` out `HEAD_W`: signed heading, equal to `acc[ACC_W-1 -: HEAD_W]`.
- `LED` out 8: `heading[HEAD_W-1 -: 8]`.

## Operation
**Internal registers**
- `acc`: signed, `ACC_W = HEAD_W + FRAC_W` bits, wraps modulo `2^ACC_W`.
- `sum`: signed, `RATE_W + CAL_LOG2` bits.
- `cnt`: `CAL_LOG2 + 1` bits.
- `offset`: signed, `RATE_W` bits.

**FSM states: IDLE, CAL, RUN**
- IDLE:
  - `vld` is ignored.
  - On `strt_cal`: clear `sum`, `cnt` and `acc`, then go to CAL.
- CAL:
  - Each `vld` does `sum += sext(yaw_rt)` and `cnt++`.
  - When the `vld` that makes `cnt == 2^CAL_LOG2` is accepted: `offset <= (sum + yaw_rt) >>> CAL_LOG2` (arithmetic shift, truncating toward −∞), `cal_done` pulses on the next cycle, and the FSM goes to RUN.
  - `strt_cal` in CAL clears `sum` and `cnt` and restarts counting.
- RUN, on each `vld` with `moving` high:
  - `c = sat_RATE_W(yaw_rt − offset)`. The subtraction is done at `RATE_W + 1` bits and saturated to `RATE_W` bits.
  - `r = (|c| < DEADBAND) ? 0 : c`.
  - Fusion term:
    - `Q = 2^(ACC_W−2)`.
    - `T` = `acc` rounded to the nearest multiple of `Q`, computed as `(acc + Q/2)` with the low `ACC_W−2` bits cleared, evaluated modulo `2^ACC_W`.
    - `e = T − acc` as a signed `ACC_W`-bit value.
    - If `lftIR|rghtIR`: `f = sign(e) · min(|e|, 2^FUSE_SHIFT)`. Otherwise `f = 0`.
  - `acc <= acc + sext(r) + f`, modulo `2^ACC_W`, so the heading wraps `0x7FF → 0x800`.
- RUN, on `vld` with `moving` low: `acc` is unchanged, but `rdy` still pulses.
- `strt_cal` in RUN clears `acc`, `sum` and `cnt` and goes to CAL. `offset` keeps its old value until the new calibration completes.
- `rst` forces IDLE and clears `acc`, `sum`, `cnt` and `offset`. It overrides every other input.

## Timing
- Reset values: `cal_done = 0`, `rdy = 0`, `heading = 0`, `LED = 0`.
- `vld` is accepted on clock edge N; `heading` and `rdy` are valid in cycle N+1. Latency is 1 cycle and throughput is one sample per clock.
- `rdy` pulses only in RUN and is high for exactly one cycle per accepted `vld`.
- `cal_done` is high for exactly one cycle. It goes high in the cycle after the final calibration `vld`, which is the same cycle the FSM enters RUN.
- `strt_cal` and `vld` asserted in the same cycle: `strt_cal` wins and that `vld` is discarded.
- `lftIR` and `rghtIR` both high: fusion behaves exactly as if only one were high.
- If `acc` is already a multiple of `Q`, then `e = 0`, so `f = 0` and there is no dither.
- `heading` updates only on a RUN `vld`, a `strt_cal` (clears it to 0), or `rst`.

## Test plan
Defaults throughout, with `FAST_SIM = 1`.
1. **Reset and calibration:** assert `rst` mid-CAL after 100 samples → all outputs 0, state IDLE. Then pulse `strt_cal` and send 256 `vld` with `yaw_rt = 100` → `cal_done` pulses exactly one cycle after the 256th `vld`, and `offset = 100`.
2. **Integration:** `moving = 1`, `yaw_rt = 2148` → one `vld` gives `heading = 1` with `rdy` high the next cycle. A `vld` with `yaw_rt = 100` leaves `heading` unchanged. With `moving = 0`, a `vld` gives no change but `rdy` still pulses.
3. **Deadband and saturation:** `yaw_rt = 103` → `heading` unchanged. With `offset = 100`, `yaw_rt = −32768` gives `c = −32768` saturated, i.e. −16 heading LSBs.
4. **Wrap:** 2047 `vld` at `yaw_rt = 2148` → `heading = 0x7FF`. One more → `0x800`.
5. **Fusion:** start from `acc = 2048` (`heading = 1`), `lftIR = 1`, zero rate → `acc` drops 16 per `vld` and reaches 0 after 128 `vld`, then stays at 0. With `acc = 0x7FF << 11`, the target is `0x800 << 11` and `acc` rises to it.
6. **Restart:** `strt_cal` in RUN together with `vld` → that `vld` is discarded, `heading = 0`, and a full 256-sample calibration is required before the next `cal_done`.
